// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state type and default bus widths for the two-master Wishbone arbiter
package wb_arb_pkg;

  localparam int WB_DATA_WIDTH_DEF = 32;
  localparam int WB_ADDR_WIDTH_DEF = 32;
  localparam int WB_SEL_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/wb_arb_pick.sv
// rtl/wb_arb_pick.sv - combinational winner select for a request taken from IDLE
// WB_ARB_RR_EN selects round-robin (other-than-last wins contention); otherwise master 0 has fixed priority.
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

`ifdef WB_ARB_RR_EN
  always_comb begin
    winner = MASTER0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = MASTER1;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = MASTER0;
    if (!req[0] && req[1]) begin
      winner = MASTER1;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master Wishbone arbiter with direct handover and no preemption
// Define WB_ARB_RR_EN for round-robin contention with a last_o register; default is fixed priority to master 0.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WB_DATA_WIDTH = WB_DATA_WIDTH_DEF,
  parameter int WB_ADDR_WIDTH = WB_ADDR_WIDTH_DEF,
  parameter int WB_SEL_WIDTH  = WB_SEL_WIDTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef WB_ARB_RR_EN
  output logic                     last_o,
`endif
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic                     m0_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_cyc_i,
  output logic                     m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic                     m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_cyc_i,
  output logic                     m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic                     s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] req;
  logic       winner;
  logic       last_q;

  assign req = {m1_cyc_i, m0_cyc_i};

  wb_arb_pick u_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset value 1 makes master 0 the first contention winner under round-robin.
`ifdef WB_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= MASTER1;
    end else if (state_d == GNT0 && state_q != GNT0) begin
      last_q <= MASTER0;
    end else if (state_d == GNT1 && state_q != GNT1) begin
      last_q <= MASTER1;
    end
  end

  assign last_o = last_q;
`else
  assign last_q = MASTER1;
`endif

  // The owner keeps the bus while its cyc is high; release hands over directly if the other master waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = (winner == MASTER1) ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i & m0_cyc_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i & m1_cyc_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench: vector table, hand sequences and random traffic against a reference model
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]  s_sel_o;
`ifdef WB_ARB_RR_EN
  logic        last_o;
`endif

  always #5 clk_i = ~clk_i;

  wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
`ifdef WB_ARB_RR_EN
    .last_o(last_o),
`endif
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_data_i(s_data_i)
  );

  int checks = 0;
  int failures = 0;
  int own = -1;     // current bus owner in the model, -1 when nobody holds it
  int last_m = 1;   // most recently granted master in the model

  typedef struct {
    logic rst, c0, c1, ack;
    logic e_cyc, e_a0, e_a1;
    int   e_gnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic cyc_of(input int m);
    return (m == 0) ? m0_cyc_i : m1_cyc_i;
  endfunction

  function automatic void model_edge();
    int nxt;
    if (rst_i) begin
      own = -1;
      last_m = 1;
    end else begin
      nxt = own;
      if (own >= 0) begin
        if (!cyc_of(own)) nxt = cyc_of(1 - own) ? 1 - own : -1;
      end else if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_RR_EN
        nxt = 1 - last_m;
`else
        nxt = 0;
`endif
      end else if (m0_cyc_i) begin
        nxt = 0;
      end else if (m1_cyc_i) begin
        nxt = 1;
      end
      if (nxt >= 0 && nxt != own) last_m = nxt;
      own = nxt;
    end
  endfunction

  task automatic check_all();
    logic [31:0] ea, ed;
    logic        ewe, ecyc, estb, ea0, ea1;
    logic [3:0]  esel;
    ea = 0; ed = 0; ewe = 0; esel = 0; ecyc = 0; estb = 0; ea0 = 0; ea1 = 0;
    if (own == 0) begin
      ea = m0_addr_i; ed = m0_data_i; ewe = m0_we_i; esel = m0_sel_i;
      ecyc = m0_cyc_i; estb = m0_stb_i && m0_cyc_i; ea0 = s_ack_i;
    end else if (own == 1) begin
      ea = m1_addr_i; ed = m1_data_i; ewe = m1_we_i; esel = m1_sel_i;
      ecyc = m1_cyc_i; estb = m1_stb_i && m1_cyc_i; ea1 = s_ack_i;
    end
    chk("s_addr", s_addr_o, ea);
    chk("s_data", s_data_o, ed);
    chk("s_we", s_we_o, ewe);
    chk("s_sel", s_sel_o, esel);
    chk("s_cyc", s_cyc_o, ecyc);
    chk("s_stb", s_stb_o, estb);
    chk("m0_ack", m0_ack_o, ea0);
    chk("m1_ack", m1_ack_o, ea1);
    chk("m0_data", m0_data_o, s_data_i);
    chk("m1_data", m1_data_o, s_data_i);
`ifdef WB_ARB_RR_EN
    chk("last_o", last_o, last_m[0]);
`endif
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic edge_clk();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic rst, input logic c0, input logic c1, input logic ack);
    rst_i = rst;
    m0_cyc_i = c0; m0_stb_i = c0;
    m1_cyc_i = c1; m1_stb_i = c1;
    s_ack_i = ack;
  endtask

  task automatic fixed_fields();
    m0_addr_i = 32'h100; m0_data_i = 32'hCAFEF00D; m0_we_i = 1'b1; m0_sel_i = 4'hF;
    m1_addr_i = 32'h200; m1_data_i = 32'h12345678; m1_we_i = 1'b0; m1_sel_i = 4'h3;
    s_data_i  = 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    edge_clk();
    edge_clk();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] gnt_addr(input int g);
    return (g == 0) ? 32'h100 : (g == 1) ? 32'h200 : 32'h0;
  endfunction

  initial begin
    int m0_acks;
    int grants[$];
    logic prev_cyc;
    logic [31:0] prev_addr;
    logic drop0, drop1, ack_now;

    fixed_fields();
    do_reset();
    settle();
    chk("reset_s_cyc", s_cyc_o, 1'b0);
    chk("reset_s_addr", s_addr_o, 32'h0);

    vecs[0] = '{0, 1, 0, 0, 0, 0, 0, 2};
    vecs[1] = '{0, 1, 0, 0, 1, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 1, 1, 1, 0, 0};
    vecs[3] = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 1, 0, 1, 1};
    vecs[5] = '{0, 1, 1, 0, 1, 0, 0, 1};
    vecs[6] = '{0, 1, 0, 1, 0, 0, 1, 1};
    vecs[7] = '{0, 0, 0, 1, 0, 1, 0, 0};
    vecs[8] = '{0, 1, 1, 1, 0, 0, 0, 2};
`ifdef WB_ARB_RR_EN
    vecs[9] = '{0, 1, 1, 0, 1, 0, 0, 1};
`else
    vecs[9] = '{0, 1, 1, 0, 1, 0, 0, 0};
`endif
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].c0, vecs[i].c1, vecs[i].ack);
      #1;
      chk($sformatf("vec%0d_cyc", i), s_cyc_o, vecs[i].e_cyc);
      chk($sformatf("vec%0d_m0ack", i), m0_ack_o, vecs[i].e_a0);
      chk($sformatf("vec%0d_m1ack", i), m1_ack_o, vecs[i].e_a1);
      chk($sformatf("vec%0d_gnt", i), s_addr_o, gnt_addr(vecs[i].e_gnt));
      check_all();
      edge_clk();
    end

    // Burst hold: 8 beats with two wait states each, m1 joins at beat 2.
    do_reset();
    m0_acks = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    edge_clk();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, 1'b1, (b >= 2), (k == 2));
        settle();
        chk("burst_owner", s_addr_o, 32'h100);
        chk("burst_m1_ack", m1_ack_o, 1'b0);
        if (m0_ack_o) m0_acks++;
        edge_clk();
      end
    end
    chk("burst_acks", m0_acks, 8);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    edge_clk();
    settle();
    chk("burst_handover_addr", s_addr_o, 32'h200);
    chk("burst_handover_cyc", s_cyc_o, 1'b1);
    edge_clk();

    // Back-to-back single transfers from both masters.
    do_reset();
    drop0 = 0; drop1 = 0; prev_cyc = 0; prev_addr = 0;
    for (int t = 0; t < 24; t++) begin
      ack_now = (own >= 0) && cyc_of(own);
      drive(1'b0, !drop0, !drop1, 1'b0);
      ack_now = (own >= 0) && cyc_of(own);
      s_ack_i = ack_now;
      settle();
      if (s_cyc_o && (!prev_cyc || s_addr_o != prev_addr)) grants.push_back(s_addr_o == 32'h200);
      prev_cyc = s_cyc_o; prev_addr = s_addr_o;
      drop0 = ack_now && own == 0;
      drop1 = ack_now && own == 1;
      edge_clk();
    end
    chk("fair_count_ok", grants.size() >= 8, 1'b1);
    for (int g = 0; g < 8 && g < grants.size(); g++) chk($sformatf("fair_gnt%0d", g), grants[g], g % 2);

    // Reset mid-transaction, late ack, then contention.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle(); edge_clk();
    settle(); chk("rst_stb_up", s_stb_o, 1'b1); edge_clk();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    settle(); edge_clk();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_late_m0ack", m0_ack_o, 1'b0);
    chk("rst_late_m1ack", m1_ack_o, 1'b0);
    edge_clk();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    settle(); edge_clk();
    settle();
    chk("rst_contend_m0", s_addr_o, 32'h100);
    edge_clk();

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < 400; r++) begin
      rst_i = ($urandom_range(0, 39) == 0);
      m0_cyc_i = $urandom_range(0, 3) != 0; m0_stb_i = $urandom_range(0, 1);
      m1_cyc_i = $urandom_range(0, 3) != 0; m1_stb_i = $urandom_range(0, 1);
      s_ack_i = $urandom_range(0, 1);
      m0_addr_i = $urandom; m0_data_i = $urandom; m0_we_i = $urandom_range(0, 1); m0_sel_i = 4'($urandom);
      m1_addr_i = $urandom; m1_data_i = $urandom; m1_we_i = $urandom_range(0, 1); m1_sel_i = 4'($urandom);
      s_data_i = $urandom;
      settle();
      edge_clk();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
